i2s_xmtr: RTL

I2S transmitter and bit-clock master, the counterpart of `i2s_rcvr`. It accepts stereo sample pairs over a valid/ready handshake and serialises them MSB-first with the standard one-bit I2S delay. It derives `bck` (clk/2) and `lrck` itself, so it can drive `i2s_rcvr` directly at 24 MHz `clk` / 12 MHz `bck`.

---
 rtl/i2s_xmtr.sv | 109 ++++++++++
 1 files changed

// File: rtl/i2s_xmtr.sv
// I2S transmitter and bit-clock master: takes stereo pairs over valid/ready and
// serialises them MSB-first with the one-bit I2S delay; bck = clk/2, lrck local.
module i2s_xmtr #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SLOT_BCKS  = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    output logic                  bck,
    output logic                  lrck,
    output logic                  data,
    output logic                  underrun
);

    localparam int unsigned    P_W    = (SLOT_BCKS > 1) ? $clog2(SLOT_BCKS) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(SLOT_BCKS - 1);
    localparam logic [P_W-1:0] P_DATA = P_W'(DATA_WIDTH);

    logic [P_W-1:0]        p, p_d;
    logic                  bck_d, lrck_d, data_d, underrun_d;
    logic                  hold_full, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_left, hold_left_d, hold_right, hold_right_d;
    logic [DATA_WIDTH-1:0] sh_left, sh_left_d, sh_right, sh_right_d;
    logic                  accept;

    assign in_ready = !hold_full && !reset;
    assign accept   = in_valid && in_ready;

    // Next-state: slot activity only on edges where bck falls (bck currently 1)
    always_comb begin
        bck_d        = ~bck;
        lrck_d       = lrck;
        p_d          = p;
        data_d       = data;
        underrun_d   = 1'b0;
        hold_full_d  = hold_full;
        hold_left_d  = hold_left;
        hold_right_d = hold_right;
        sh_left_d    = sh_left;
        sh_right_d   = sh_right;

        if (accept) begin
            hold_left_d  = in_left;
            hold_right_d = in_right;
            hold_full_d  = 1'b1;
        end

        if (bck) begin
            if (p == P_LAST) begin
                p_d    = '0;
                lrck_d = ~lrck;
                // Frame start: load uses hold as it was before this edge
                if (lrck) begin
                    if (hold_full) begin
                        sh_left_d   = hold_left;
                        sh_right_d  = hold_right;
                        hold_full_d = 1'b0;
                    end else begin
                        sh_left_d  = '0;
                        sh_right_d = '0;
                        underrun_d = 1'b1;
                    end
                end
            end else begin
                p_d = p + P_W'(1);
                if (p >= P_DATA) begin
                    data_d = 1'b0;
                end else if (lrck) begin
                    data_d     = sh_right[DATA_WIDTH-1];
                    sh_right_d = {sh_right[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    data_d    = sh_left[DATA_WIDTH-1];
                    sh_left_d = {sh_left[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bck        <= 1'b0;
            lrck       <= 1'b1;
            data       <= 1'b0;
            underrun   <= 1'b0;
            p          <= P_LAST;
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
            sh_left    <= '0;
            sh_right   <= '0;
        end else begin
            bck        <= bck_d;
            lrck       <= lrck_d;
            data       <= data_d;
            underrun   <= underrun_d;
            p          <= p_d;
            hold_full  <= hold_full_d;
            hold_left  <= hold_left_d;
            hold_right <= hold_right_d;
            sh_left    <= sh_left_d;
            sh_right   <= sh_right_d;
        end
    end

endmodule
